// File: rtl/bus_arbiter_if.sv
// bus_if: shared CPU-side bus (one-cycle read latency) between the arbiter and
// the RAM/ROM/UART address decoder.
interface bus_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic            ren;
  logic [AW-1:0]   raddr;
  logic [DW-1:0]   rdata;
  logic            wen;
  logic [AW-1:0]   waddr;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] bytemask;

  modport master (output ren, raddr, wen, waddr, wdata, bytemask, input rdata);
  modport slave  (input ren, raddr, wen, waddr, wdata, bytemask, output rdata);
endinterface

// File: rtl/bus_arbiter.sv
// bus_arbiter: grants the shared bus to the fetch unit (m0) or LSU (m1) and tags returning read data.
// Round-robin by default; define BUS_ARB_FIXED_PRIO_EN to make m1 win every contended cycle.
module bus_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            m0_ren,
  input  logic [AW-1:0]   m0_raddr,
  input  logic            m0_wen,
  input  logic [AW-1:0]   m0_waddr,
  input  logic [DW-1:0]   m0_wdata,
  input  logic [DW/8-1:0] m0_bytemask,
  output logic            m0_gnt,
  output logic            m0_rvalid,
  output logic [DW-1:0]   m0_rdata,
  input  logic            m1_ren,
  input  logic [AW-1:0]   m1_raddr,
  input  logic            m1_wen,
  input  logic [AW-1:0]   m1_waddr,
  input  logic [DW-1:0]   m1_wdata,
  input  logic [DW/8-1:0] m1_bytemask,
  output logic            m1_gnt,
  output logic            m1_rvalid,
  output logic [DW-1:0]   m1_rdata,
  bus_if.master           bus
);
  localparam int BW = DW / 8;

  typedef struct packed {
    logic          ren;
    logic [AW-1:0] raddr;
    logic          wen;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic [BW-1:0] bytemask;
  } req_t;

  req_t [1:0] rq;
  req_t       win;
  logic [1:0] req;
  logic [1:0] gnt;
  logic [1:0] rv;
  logic       arb_en;
  logic       last;

  assign rq[0] = '{m0_ren, m0_raddr, m0_wen, m0_waddr, m0_wdata, m0_bytemask};
  assign rq[1] = '{m1_ren, m1_raddr, m1_wen, m1_waddr, m1_wdata, m1_bytemask};
  assign req   = {rq[1].ren | rq[1].wen, rq[0].ren | rq[0].wen};

  // Purely combinational grant: requests are never registered, so a lone
  // requester is served in the same cycle it asserts.
  always_comb begin
    gnt = 2'b00;
    if (arb_en) begin
      unique case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
`ifdef BUS_ARB_FIXED_PRIO_EN
        2'b11:   gnt = 2'b10;
`else
        2'b11:   gnt = last ? 2'b01 : 2'b10;
`endif
        default: gnt = 2'b00;
      endcase
    end
  end

  // With no winner the address/data lanes follow m0; only the strobes matter.
  assign win = gnt[1] ? rq[1] : rq[0];

  assign bus.ren      = win.ren & (|gnt);
  assign bus.wen      = win.wen & (|gnt);
  assign bus.raddr    = win.raddr;
  assign bus.waddr    = win.waddr;
  assign bus.wdata    = win.wdata;
  assign bus.bytemask = win.bytemask;

  assign m0_gnt    = gnt[0];
  assign m1_gnt    = gnt[1];
  assign m0_rvalid = rv[0];
  assign m1_rvalid = rv[1];
  assign m0_rdata  = bus.rdata;
  assign m1_rdata  = bus.rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arb_en <= 1'b0;
      last   <= 1'b1;
      rv     <= 2'b00;
    end else begin
      arb_en <= 1'b1;
      if (|gnt) last <= gnt[1];
      // Only the granted side can have an outstanding read, so rv is one-hot or zero.
      rv <= gnt & {rq[1].ren, rq[0].ren};
    end
  end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed and randomized checks of bus_arbiter against a
// cycle-level reference model of the grant policy and read-return tagging.
module tb_bus_arbiter;
`ifdef BUS_ARB_FIXED_PRIO_EN
  localparam int FIRST = 1;
`else
  localparam int FIRST = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_ren, m0_wen, m1_ren, m1_wen;
  logic [31:0] m0_raddr, m0_waddr, m0_wdata, m1_raddr, m1_waddr, m1_wdata;
  logic [3:0]  m0_bytemask, m1_bytemask;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  int          mdl_last;
  bit          mdl_en;
  bit          erv0, erv1;
  logic [31:0] erdata;

  bus_if #(.AW(32), .DW(32)) bus_i ();

  bus_arbiter #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_ren(m0_ren), .m0_raddr(m0_raddr), .m0_wen(m0_wen), .m0_waddr(m0_waddr),
    .m0_wdata(m0_wdata), .m0_bytemask(m0_bytemask), .m0_gnt(m0_gnt),
    .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_ren(m1_ren), .m1_raddr(m1_raddr), .m1_wen(m1_wen), .m1_waddr(m1_waddr),
    .m1_wdata(m1_wdata), .m1_bytemask(m1_bytemask), .m1_gnt(m1_gnt),
    .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .bus(bus_i)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] hash(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
  endfunction

  // downstream memory: one-cycle read latency
  always @(posedge clk) if (bus_i.ren) bus_i.rdata <= hash(bus_i.raddr);

  // winner index, or -1 when nobody is granted
  function automatic int pick(input bit r0, input bit r1);
    if (!mdl_en || (!r0 && !r1)) return -1;
    if (r0 && !r1) return 0;
    if (r1 && !r0) return 1;
`ifdef BUS_ARB_FIXED_PRIO_EN
    return 1;
`else
    return 1 - mdl_last;
`endif
  endfunction

  task automatic model_reset();
    mdl_last = 1; mdl_en = 0; erv0 = 0; erv1 = 0;
  endtask

  task automatic model_edge();
    int w;
    w = pick(m0_ren | m0_wen, m1_ren | m1_wen);
    if (!rst_n) begin model_reset(); return; end
    erv0 = (w == 0) && m0_ren;
    erv1 = (w == 1) && m1_ren;
    if (w == 0) erdata = hash(m0_raddr);
    else if (w == 1) erdata = hash(m1_raddr);
    if (w >= 0) mdl_last = w;
    mdl_en = 1;
  endtask

  task automatic next_cycle();
    model_edge();
    @(posedge clk); #1;
  endtask

  task automatic idle_all();
    m0_ren = 0; m0_wen = 0; m1_ren = 0; m1_wen = 0;
    m0_raddr = 0; m0_waddr = 0; m0_wdata = 0; m0_bytemask = 0;
    m1_raddr = 0; m1_waddr = 0; m1_wdata = 0; m1_bytemask = 0;
  endtask

  task automatic test_reset_start();
    rst_n = 0; idle_all(); model_reset();
    m0_ren = 1; m0_raddr = 32'h1000_0000; m1_ren = 1; m1_raddr = 32'h0000_0040;
    repeat (2) @(posedge clk);
    #3;
    n_tests++; if ({m1_gnt, m0_gnt} !== 2'b00) begin n_fail++; $display("FAIL rst_gnt got %b want 00", {m1_gnt, m0_gnt}); end
    n_tests++; if ({m1_rvalid, m0_rvalid} !== 2'b00) begin n_fail++; $display("FAIL rst_rvalid got %b want 00", {m1_rvalid, m0_rvalid}); end
    n_tests++; if ({bus_i.wen, bus_i.ren} !== 2'b00) begin n_fail++; $display("FAIL rst_strobes got %b want 00", {bus_i.wen, bus_i.ren}); end
    @(posedge clk); #1 rst_n = 1; #2;
    n_tests++; if ({m1_gnt, m0_gnt} !== 2'b00) begin n_fail++; $display("FAIL start_c0_gnt got %b want 00", {m1_gnt, m0_gnt}); end
    n_tests++; if (bus_i.ren !== 1'b0) begin n_fail++; $display("FAIL start_c0_ren got %b want 0", bus_i.ren); end
    next_cycle(); #2;
    n_tests++; if ({m1_gnt, m0_gnt} !== (FIRST ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL start_c1_gnt got %b want %b", {m1_gnt, m0_gnt}, (FIRST ? 2'b10 : 2'b01)); end
    n_tests++; if (bus_i.raddr !== (FIRST ? 32'h40 : 32'h1000_0000)) begin n_fail++; $display("FAIL start_c1_raddr got %h", bus_i.raddr); end
    next_cycle();
    if (FIRST == 1) m1_ren = 0; else m0_ren = 0;
    #2;
    n_tests++; if ({m1_gnt, m0_gnt} !== (FIRST ? 2'b01 : 2'b10)) begin n_fail++; $display("FAIL start_c2_gnt got %b want %b", {m1_gnt, m0_gnt}, (FIRST ? 2'b01 : 2'b10)); end
    n_tests++; if ({m1_rvalid, m0_rvalid} !== (FIRST ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL start_c2_rvalid got %b", {m1_rvalid, m0_rvalid}); end
    n_tests++; if (m0_rdata !== hash(FIRST ? 32'h40 : 32'h1000_0000)) begin n_fail++; $display("FAIL start_c2_rdata got %h", m0_rdata); end
    next_cycle();
    idle_all(); #2;
    n_tests++; if ({m1_rvalid, m0_rvalid} !== (FIRST ? 2'b01 : 2'b10)) begin n_fail++; $display("FAIL start_c3_rvalid got %b", {m1_rvalid, m0_rvalid}); end
    next_cycle();
  endtask

  task automatic test_contention();
    int w;
    idle_all();
    m0_ren = 1; m0_raddr = $urandom; m1_ren = 1; m1_raddr = $urandom;
    for (int c = 0; c < 8; c++) begin
      #2;
      w = pick(1, 1);
      n_tests++; if ({m1_gnt, m0_gnt} !== {w == 1, w == 0}) begin n_fail++; $display("FAIL cont_gnt c%0d got %b want %b", c, {m1_gnt, m0_gnt}, {w == 1, w == 0}); end
      n_tests++; if ({m1_rvalid, m0_rvalid} !== {erv1, erv0}) begin n_fail++; $display("FAIL cont_rvalid c%0d got %b want %b", c, {m1_rvalid, m0_rvalid}, {erv1, erv0}); end
      n_tests++; if ((m0_rvalid & m1_rvalid) !== 1'b0) begin n_fail++; $display("FAIL cont_both_rvalid c%0d got 1 want 0", c); end
      if (erv0 | erv1) begin
        n_tests++; if (m0_rdata !== erdata) begin n_fail++; $display("FAIL cont_rdata c%0d got %h want %h", c, m0_rdata, erdata); end
      end
      next_cycle();
      if (w == 0) m0_raddr = $urandom; else m1_raddr = $urandom;
    end
    m1_ren = 0; #2;
    n_tests++; if ({m1_gnt, m0_gnt} !== 2'b01) begin n_fail++; $display("FAIL cont_drop_m1 got %b want 01", {m1_gnt, m0_gnt}); end
    next_cycle();
    idle_all(); #2;
    n_tests++; if ({m1_rvalid, m0_rvalid} !== {erv1, erv0}) begin n_fail++; $display("FAIL cont_drain got %b want %b", {m1_rvalid, m0_rvalid}, {erv1, erv0}); end
    next_cycle();
  endtask

  task automatic test_m1_rw();
    idle_all();
    m1_ren = 1; m1_raddr = 32'h0000_0080;
    m1_wen = 1; m1_waddr = 32'h2000_0000; m1_wdata = 32'h0000_00A5; m1_bytemask = 4'h1;
    #2;
    n_tests++; if ({m1_gnt, m0_gnt} !== 2'b10) begin n_fail++; $display("FAIL rw_gnt got %b want 10", {m1_gnt, m0_gnt}); end
    n_tests++; if ({bus_i.wen, bus_i.ren} !== 2'b11) begin n_fail++; $display("FAIL rw_strobes got %b want 11", {bus_i.wen, bus_i.ren}); end
    n_tests++; if (bus_i.raddr !== 32'h80) begin n_fail++; $display("FAIL rw_raddr got %h want 00000080", bus_i.raddr); end
    n_tests++; if ({bus_i.waddr, bus_i.wdata, bus_i.bytemask} !== {32'h2000_0000, 32'hA5, 4'h1}) begin n_fail++; $display("FAIL rw_wfields got %h %h %h", bus_i.waddr, bus_i.wdata, bus_i.bytemask); end
    next_cycle();
    idle_all(); #2;
    n_tests++; if ({m1_rvalid, m0_rvalid} !== 2'b10) begin n_fail++; $display("FAIL rw_rvalid got %b want 10", {m1_rvalid, m0_rvalid}); end
    n_tests++; if (m1_rdata !== hash(32'h80)) begin n_fail++; $display("FAIL rw_rdata got %h want %h", m1_rdata, hash(32'h80)); end
    next_cycle();
  endtask

  task automatic new_req(input int x);
    int k;
    k = $urandom_range(1, 3);
    if (x == 0) begin
      m0_ren = k[0]; m0_wen = k[1]; m0_raddr = $urandom; m0_waddr = $urandom;
      m0_wdata = $urandom; m0_bytemask = 4'($urandom);
    end else begin
      m1_ren = k[0]; m1_wen = k[1]; m1_raddr = $urandom; m1_waddr = $urandom;
      m1_wdata = $urandom; m1_bytemask = 4'($urandom);
    end
  endtask

  task automatic test_random();
    bit p0, p1;
    int w;
    logic e_ren, e_wen;
    logic [31:0] e_raddr, e_waddr, e_wdata;
    logic [3:0] e_bm;
    p0 = 0; p1 = 0; idle_all();
    for (int c = 0; c < 400; c++) begin
      if (!p0 && $urandom_range(0, 99) < 55) begin p0 = 1; new_req(0); end
      if (!p1 && $urandom_range(0, 99) < 55) begin p1 = 1; new_req(1); end
      if (!p0) begin m0_ren = 0; m0_wen = 0; end
      if (!p1) begin m1_ren = 0; m1_wen = 0; end
      #2;
      w = pick(p0, p1);
      e_ren = 0; e_wen = 0; e_raddr = 0; e_waddr = 0; e_wdata = 0; e_bm = 0;
      if (w == 0) begin
        e_ren = m0_ren; e_wen = m0_wen; e_raddr = m0_raddr; e_waddr = m0_waddr; e_wdata = m0_wdata; e_bm = m0_bytemask;
      end else if (w == 1) begin
        e_ren = m1_ren; e_wen = m1_wen; e_raddr = m1_raddr; e_waddr = m1_waddr; e_wdata = m1_wdata; e_bm = m1_bytemask;
      end
      n_tests++; if ({m1_gnt, m0_gnt} !== {w == 1, w == 0}) begin n_fail++; $display("FAIL rnd_gnt c%0d got %b want %b", c, {m1_gnt, m0_gnt}, {w == 1, w == 0}); end
      n_tests++; if ({bus_i.wen, bus_i.ren} !== {e_wen, e_ren}) begin n_fail++; $display("FAIL rnd_strobes c%0d got %b want %b", c, {bus_i.wen, bus_i.ren}, {e_wen, e_ren}); end
      if (e_ren) begin
        n_tests++; if (bus_i.raddr !== e_raddr) begin n_fail++; $display("FAIL rnd_raddr c%0d got %h want %h", c, bus_i.raddr, e_raddr); end
      end
      if (e_wen) begin
        n_tests++; if ({bus_i.waddr, bus_i.wdata, bus_i.bytemask} !== {e_waddr, e_wdata, e_bm}) begin n_fail++; $display("FAIL rnd_wfields c%0d got %h %h %h want %h %h %h", c, bus_i.waddr, bus_i.wdata, bus_i.bytemask, e_waddr, e_wdata, e_bm); end
      end
      n_tests++; if ({m1_rvalid, m0_rvalid} !== {erv1, erv0}) begin n_fail++; $display("FAIL rnd_rvalid c%0d got %b want %b", c, {m1_rvalid, m0_rvalid}, {erv1, erv0}); end
      if (erv0 | erv1) begin
        n_tests++; if ((erv0 ? m0_rdata : m1_rdata) !== erdata) begin n_fail++; $display("FAIL rnd_rdata c%0d got %h want %h", c, (erv0 ? m0_rdata : m1_rdata), erdata); end
      end
      next_cycle();
      if (w == 0) p0 = 0;
      if (w == 1) p1 = 0;
    end
    idle_all(); #2;
    n_tests++; if ({m1_rvalid, m0_rvalid} !== {erv1, erv0}) begin n_fail++; $display("FAIL rnd_drain got %b want %b", {m1_rvalid, m0_rvalid}, {erv1, erv0}); end
    next_cycle();
  endtask

  task automatic test_async_reset();
    idle_all();
    m0_ren = 1; m0_raddr = 32'h0000_0300; #2;
    n_tests++; if (m0_gnt !== 1'b1) begin n_fail++; $display("FAIL arst_gnt got %b want 1", m0_gnt); end
    next_cycle();
    m0_ren = 0; #1;
    n_tests++; if (m0_rvalid !== 1'b1) begin n_fail++; $display("FAIL arst_rvalid_pre got %b want 1", m0_rvalid); end
    #1 rst_n = 0; #1;
    model_reset();
    n_tests++; if (m0_rvalid !== 1'b0) begin n_fail++; $display("FAIL arst_rvalid_clr got %b want 0", m0_rvalid); end
    @(posedge clk); #1 rst_n = 1;
    m0_ren = 1; m0_raddr = 32'h0000_0400; m1_ren = 1; m1_raddr = 32'h0000_0500; #2;
    n_tests++; if ({m1_gnt, m0_gnt} !== 2'b00) begin n_fail++; $display("FAIL arst_c0_gnt got %b want 00", {m1_gnt, m0_gnt}); end
    next_cycle(); #2;
    n_tests++; if ({m1_gnt, m0_gnt} !== (FIRST ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL arst_c1_gnt got %b want %b", {m1_gnt, m0_gnt}, (FIRST ? 2'b10 : 2'b01)); end
    next_cycle();
    if (FIRST == 1) m1_ren = 0; else m0_ren = 0;
    #2;
    n_tests++; if ({m1_gnt, m0_gnt} !== (FIRST ? 2'b01 : 2'b10)) begin n_fail++; $display("FAIL arst_c2_gnt got %b", {m1_gnt, m0_gnt}); end
    next_cycle();
    idle_all(); #2;
    n_tests++; if ({m1_rvalid, m0_rvalid} !== {erv1, erv0}) begin n_fail++; $display("FAIL arst_c3_rvalid got %b want %b", {m1_rvalid, m0_rvalid}, {erv1, erv0}); end
    next_cycle();
  endtask

  initial begin
    test_reset_start();
    test_contention();
    test_m1_rw();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
